colour_change: RTL and testbench



---
 rtl/colour_change_pkg.sv | 39 +++
 rtl/colour_change_btn_sync_edge.sv | 45 ++++
 rtl/colour_change.sv | 179 +++++++++++++++++
 tb/tb_colour_change.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/colour_change_pkg.sv
// -----------------------------------------------------------------------------
// colour_change_pkg
//   Shared definitions for the colour_change pixel filter:
//     - channel width and packed RGB pixel type
//     - colour-mode encodings (2-bit, stored in pending/active mode regs)
//     - greyscale luma weights and the luma helper function
// -----------------------------------------------------------------------------
package colour_change_pkg;

   localparam int CH_W = 8;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   // Colour-mode encodings
   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_INV  = 2'd1;
   localparam logic [1:0] MODE_GREY = 2'd2;
   localparam logic [1:0] MODE_ROT  = 2'd3;

   // Luma weights; they sum to 256 so white maps exactly to 255.
   localparam logic [15:0] GREY_WR = 16'd77;
   localparam logic [15:0] GREY_WG = 16'd150;
   localparam logic [15:0] GREY_WB = 16'd29;

   // Y = (77R + 150G + 29B) >> 8. Maximum sum is 65280, so a 16-bit
   // accumulator never overflows.
   function automatic logic [CH_W-1:0] grey_luma(input logic [CH_W-1:0] r,
                                                 input logic [CH_W-1:0] g,
                                                 input logic [CH_W-1:0] b);
      logic [15:0] acc;
      acc = GREY_WR * 16'(r) + GREY_WG * 16'(g) + GREY_WB * 16'(b);
      return acc[15:8];
   endfunction

endpackage

// File: rtl/colour_change_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
//   Synchronises an asynchronous button bus into the clk domain and emits a
//   one-cycle pulse on each rising edge of every bit. A held button therefore
//   produces exactly one pulse.
//
//   Ports:
//     clk       in   clock
//     n_rst     in   asynchronous active-low reset
//     async_in  in   WIDTH  raw button levels (asynchronous)
//     pulse     out  WIDTH  one-cycle rising-edge pulses
//
//   SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] pulse
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/colour_change.sv
// -----------------------------------------------------------------------------
// colour_change
//   Pixel-stream colour filter. Applies one of four per-pixel transforms
//   (passthrough, invert, greyscale, channel rotate) to a 24-bit RGB stream
//   and forwards hsync/vsync/VDE with the same fixed 2-cycle latency.
//
//   Interface: there is no valid/ready handshake and no backpressure. One
//   pixel is accepted on every rising clk edge unconditionally; VDE only
//   marks active pixels (data is blanked to 0 when VDE is low).
//
//   Mode control: buttons edit pending_mode; active_mode (the mode actually
//   applied) is loaded from pending_mode on each stage-1 vsync rise, or
//   immediately by btn[3]. Loading always takes the value pending_mode is
//   being updated to in that same cycle.
//
//   Ports:
//     clk          in   pixel clock
//     n_rst        in   asynchronous active-low reset
//     i_vid_data   in   24  pixel, [23:16]=R [15:8]=G [7:0]=B
//     i_vid_hsync  in   horizontal sync
//     i_vid_vsync  in   vertical sync
//     i_vid_VDE    in   data enable
//     btn          in   4   push-buttons (async, active-high)
//                          [0] next mode, [1] previous mode,
//                          [2] clear pending to passthrough, [3] commit now
//     o_vid_data   out  24  transformed pixel
//     o_vid_hsync  out  hsync delayed 2 cycles
//     o_vid_vsync  out  vsync delayed 2 cycles
//     o_vid_VDE    out  VDE delayed 2 cycles
// -----------------------------------------------------------------------------
module colour_change
   import colour_change_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [23:0] i_vid_data,
   input  logic        i_vid_hsync,
   input  logic        i_vid_vsync,
   input  logic        i_vid_VDE,
   input  logic [3:0]  btn,
   output logic [23:0] o_vid_data,
   output logic        o_vid_hsync,
   output logic        o_vid_vsync,
   output logic        o_vid_VDE
);

   // Stage-1 registers
   logic [23:0] s1_data;
   logic        s1_hsync;
   logic        s1_vsync;
   logic        s1_vde;
   logic        s1_vsync_d;     // previous s1_vsync, for frame-edge detect

   // Mode control
   logic [1:0]  pending_mode;
   logic [1:0]  active_mode;
   logic [1:0]  pending_next;
   logic [3:0]  btn_pulse;
   logic        vsync_rise;
   logic        commit;

   // Transform datapath
   rgb_t        pix_in;
   rgb_t        pix_out;
   logic [CH_W-1:0] luma;

   btn_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH       (4)
   ) u_btn_sync_edge (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (btn),
      .pulse    (btn_pulse)
   );

   // ---------------------------------------------------------------------
   // Stage 1
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_data    <= '0;
         s1_hsync   <= 1'b0;
         s1_vsync   <= 1'b0;
         s1_vde     <= 1'b0;
         s1_vsync_d <= 1'b0;
      end else begin
         s1_data    <= i_vid_data;
         s1_hsync   <= i_vid_hsync;
         s1_vsync   <= i_vid_vsync;
         s1_vde     <= i_vid_VDE;
         s1_vsync_d <= s1_vsync;
      end
   end

   // ---------------------------------------------------------------------
   // Mode control
   // ---------------------------------------------------------------------
   assign vsync_rise = s1_vsync & ~s1_vsync_d;
   assign commit     = btn_pulse[3] | vsync_rise;

   // Clear beats step; simultaneous up and down cancel out.
   always_comb begin
      pending_next = pending_mode;
      if (btn_pulse[2]) begin
         pending_next = MODE_PASS;
      end else if (btn_pulse[0] && !btn_pulse[1]) begin
         pending_next = pending_mode + 2'd1;
      end else if (btn_pulse[1] && !btn_pulse[0]) begin
         pending_next = pending_mode - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pending_mode <= MODE_PASS;
         active_mode  <= MODE_PASS;
      end else begin
         pending_mode <= pending_next;
         if (commit) begin
            active_mode <= pending_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Transform (combinational on stage-1 pixel)
   // ---------------------------------------------------------------------
   assign pix_in = rgb_t'(s1_data);
   assign luma   = grey_luma(pix_in.r, pix_in.g, pix_in.b);

   always_comb begin
      pix_out = pix_in;
      case (active_mode)
         MODE_INV: begin
            // 255 - c is a bitwise complement for 8-bit channels
            pix_out.r = ~pix_in.r;
            pix_out.g = ~pix_in.g;
            pix_out.b = ~pix_in.b;
         end
         MODE_GREY: begin
            pix_out.r = luma;
            pix_out.g = luma;
            pix_out.b = luma;
         end
         MODE_ROT: begin
            pix_out.r = pix_in.g;
            pix_out.g = pix_in.b;
            pix_out.b = pix_in.r;
         end
         default: begin
            pix_out = pix_in;
         end
      endcase
      if (!s1_vde) begin
         pix_out = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 (output registers)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         o_vid_data  <= '0;
         o_vid_hsync <= 1'b0;
         o_vid_vsync <= 1'b0;
         o_vid_VDE   <= 1'b0;
      end else begin
         o_vid_data  <= pix_out;
         o_vid_hsync <= s1_hsync;
         o_vid_vsync <= s1_vsync;
         o_vid_VDE   <= s1_vde;
      end
   end

endmodule

// File: tb/tb_colour_change.sv
// -----------------------------------------------------------------------------
// tb_colour_change
//   Self-checking bench for colour_change: fixed vector table, hand-written
//   button/vsync/reset sequences and randomized pixel streams checked against
//   a behavioural mode/pixel model.
// -----------------------------------------------------------------------------
module tb_colour_change;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [23:0] i_vid_data;
   logic        i_vid_hsync;
   logic        i_vid_vsync;
   logic        i_vid_VDE;
   logic [3:0]  btn;
   logic [23:0] o_vid_data;
   logic        o_vid_hsync;
   logic        o_vid_vsync;
   logic        o_vid_VDE;

   int checks = 0;
   int errors = 0;

   // Behavioural mode model
   int model_pending = 0;
   int model_active  = 0;

   // Expected {hsync, vsync, vde, data} for each driven cycle
   logic [26:0] exp_q[$];

   typedef struct {
      int          mode;
      logic [23:0] d;
      logic        hs;
      logic        vs;
      logic        vde;
      logic [23:0] exp_d;
   } vec_t;

   vec_t tbl[8];

   // ---------------------------------------------------------------------
   // Clock / DUT
   // ---------------------------------------------------------------------
   always #5 clk = ~clk;

   colour_change #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_vid_data  (i_vid_data),
      .i_vid_hsync (i_vid_hsync),
      .i_vid_vsync (i_vid_vsync),
      .i_vid_VDE   (i_vid_VDE),
      .btn         (btn),
      .o_vid_data  (o_vid_data),
      .o_vid_hsync (o_vid_hsync),
      .o_vid_vsync (o_vid_vsync),
      .o_vid_VDE   (o_vid_VDE)
   );

   // ---------------------------------------------------------------------
   // Reference pixel model
   // ---------------------------------------------------------------------
   function automatic logic [23:0] ref_pix(input int mode, input logic [23:0] d,
                                           input logic vde);
      int r, g, b, y;
      logic [23:0] res;
      r = int'(d[23:16]);
      g = int'(d[15:8]);
      b = int'(d[7:0]);
      if (!vde) return 24'h0;
      case (mode)
         0: res = d;
         1: res = {8'(255 - r), 8'(255 - g), 8'(255 - b)};
         2: begin
            y = (77 * r + 150 * g + 29 * b) / 256;
            res = {8'(y), 8'(y), 8'(y)};
         end
         default: res = {8'(g), 8'(b), 8'(r)};
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [23:0] d, input logic hs, input logic vs,
                         input logic vde);
      i_vid_data  = d;
      i_vid_hsync = hs;
      i_vid_vsync = vs;
      i_vid_VDE   = vde;
   endtask

   task automatic idle(input int n);
      set_in(24'h0, 1'b0, 1'b0, 1'b0);
      repeat (n) tick();
   endtask

   // Drive one pixel and compare the output of the pixel driven 2 cycles ago
   task automatic drive(input logic [23:0] d, input logic hs, input logic vs,
                        input logic vde);
      logic [26:0] e;
      set_in(d, hs, vs, vde);
      exp_q.push_back({hs, vs, vde, ref_pix(model_active, d, vde)});
      tick();
      if (exp_q.size() == 2) begin
         e = exp_q.pop_front();
         check("stream_data", 32'(o_vid_data), 32'(e[23:0]));
         check("stream_sync", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}),
               32'(e[26:24]));
      end
   endtask

   task automatic flush();
      drive(24'h0, 1'b0, 1'b0, 1'b0);
      exp_q.delete();
   endtask

   task automatic press(input logic [3:0] mask, input int hold);
      btn = mask;
      repeat (hold) tick();
      btn = 4'h0;
      idle(6);
      if (mask[2]) model_pending = 0;
      else if (mask[0] && !mask[1]) model_pending = (model_pending + 1) % 4;
      else if (mask[1] && !mask[0]) model_pending = (model_pending + 3) % 4;
      if (mask[3]) model_active = model_pending;
   endtask

   task automatic vsync_pulse();
      set_in(24'h0, 1'b0, 1'b1, 1'b0);
      repeat (2) tick();
      idle(4);
      model_active = model_pending;
   endtask

   task automatic set_mode(input int m);
      press(4'b0100, 3);
      repeat (m) press(4'b0001, 3);
      press(4'b1000, 3);
   endtask

   task automatic stream_fixed(input logic [23:0] d, input int n);
      repeat (n) drive(d, 1'b0, 1'b0, 1'b1);
      flush();
   endtask

   task automatic stream_rand(input int n);
      logic vs;
      for (int i = 0; i < n; i++) begin
         // vsync rises would commit pending; only toggle it when that is a no-op
         vs = (model_pending == model_active) ? 1'($urandom_range(0, 1)) : 1'b0;
         drive(24'($urandom), 1'($urandom_range(0, 1)), vs,
               ($urandom_range(0, 3) != 0));
      end
      flush();
   endtask

   // ---------------------------------------------------------------------
   // Test
   // ---------------------------------------------------------------------
   initial begin
      tbl[0] = '{0, 24'h0a141e, 1'b1, 1'b0, 1'b1, 24'h0a141e};
      tbl[1] = '{1, 24'h0080ff, 1'b0, 1'b0, 1'b1, 24'hff7f00};
      tbl[2] = '{2, 24'hffffff, 1'b0, 1'b0, 1'b1, 24'hffffff};
      tbl[3] = '{2, 24'h6432c8, 1'b1, 1'b0, 1'b1, 24'h525252};
      tbl[4] = '{3, 24'h010203, 1'b0, 1'b0, 1'b1, 24'h020301};
      tbl[5] = '{1, 24'h123456, 1'b0, 1'b1, 1'b0, 24'h000000};
      tbl[6] = '{2, 24'habcdef, 1'b1, 1'b0, 1'b0, 24'h000000};
      tbl[7] = '{2, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000};

      // Reset with busy inputs: outputs must stay 0
      n_rst = 1'b0;
      btn   = 4'h0;
      set_in(24'habcdef, 1'b1, 1'b1, 1'b1);
      repeat (3) tick();
      check("reset_data", 32'(o_vid_data), 32'h0);
      check("reset_sync", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}), 32'h0);
      n_rst = 1'b1;
      idle(2);

      // Passthrough straight after reset
      stream_fixed(24'h0a141e, 4);

      // Table-driven vectors, each in its required mode
      for (int i = 0; i < 8; i++) begin
         set_mode(tbl[i].mode);
         set_in(tbl[i].d, tbl[i].hs, tbl[i].vs, tbl[i].vde);
         tick();
         idle(1);
         check($sformatf("tbl%0d_data", i), 32'(o_vid_data), 32'(tbl[i].exp_d));
         check($sformatf("tbl%0d_sync", i),
               32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}),
               32'({tbl[i].hs, tbl[i].vs, tbl[i].vde}));
         idle(3);
      end

      // btn[0] alone must not change the output before a vsync rise
      set_mode(0);
      press(4'b0001, 3);
      stream_fixed(24'h0080ff, 3);
      vsync_pulse();
      stream_fixed(24'h0080ff, 3);

      // Two increments then vsync: greyscale
      set_mode(0);
      press(4'b0001, 3);
      press(4'b0001, 3);
      vsync_pulse();
      stream_fixed(24'h6432c8, 3);

      // btn[1] from mode 0 then btn[3]: rotate immediately
      set_mode(0);
      press(4'b0010, 3);
      press(4'b1000, 3);
      stream_fixed(24'h010203, 3);
      press(4'b0100, 3);
      vsync_pulse();
      stream_fixed(24'h010203, 3);

      // Same-cycle up+down: unchanged; clear+up: cleared
      set_mode(2);
      press(4'b0011, 3);
      vsync_pulse();
      stream_fixed(24'h6432c8, 2);
      press(4'b0101, 3);
      vsync_pulse();
      stream_fixed(24'h6432c8, 2);

      // Held btn[0]: one increment only
      set_mode(0);
      press(4'b0001, 100);
      vsync_pulse();
      stream_rand(8);

      // btn[3] with btn[0] in the same cycle commits the incremented value
      set_mode(1);
      press(4'b1001, 3);
      stream_fixed(24'h123456, 3);

      // Mid-frame reset in invert mode
      set_mode(1);
      drive(24'h112233, 1'b1, 1'b1, 1'b1);
      drive(24'h445566, 1'b1, 1'b0, 1'b1);
      drive(24'h778899, 1'b0, 1'b0, 1'b1);
      n_rst = 1'b0;
      #1;
      check("midrst_data", 32'(o_vid_data), 32'h0);
      check("midrst_sync", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}), 32'h0);
      exp_q.delete();
      model_pending = 0;
      model_active  = 0;
      tick();
      tick();
      check("midrst_hold", 32'(o_vid_data), 32'h0);
      n_rst = 1'b1;
      stream_fixed(24'h778899, 3);

      // Randomized button sequences and pixel streams
      for (int r = 0; r < 10; r++) begin
         press(4'($urandom_range(1, 15)), $urandom_range(1, 5));
         if ($urandom_range(0, 1) != 0) vsync_pulse();
         stream_rand(16);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
